instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch-side producer for the decode path. Holds the PC and requests instruction words from instruction memory over a req/ack handshake. Latches each returned word and presents Opcode and the raw immediate field to the immediate selector. Consumes the selector's PC-offset output to form branch targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 255, ack wait limit; used only when IFU_TIMEOUT_EN is defined

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous reset, active-low
PC_LdEn  in  1  advance enable from control; 0 = stall
PC_sel  in  1  0 = PC+4, 1 = PC+4+Immed_PC (branch taken)
Immed_PC  in  32  word-aligned branch offset from the immediate selector
Imem_req  out  1  fetch request, held until ack
Imem_addr  out  32  fetch address, equal to PC
Imem_ack  in  1  memory has driven Imem_data this cycle
Imem_data  in  32  instruction word
Instr  out  32  latched instruction
Opcode  out  6  Instr[31:26]
Immed_in  out  32  {16'b0, Instr[15:0]}; extension is done downstream
Instr_valid  out  1  Instr holds a fetched word for the current PC
PC  out  32  current PC
Fetch_err  out  1  ack timeout; present only with IFU_TIMEOUT_EN

Behaviour:
- Reset (Rst_n=0, async):
  - PC=RESET_PC, Instr=0, Instr_valid=0, Imem_req=0, Fetch_err=0, state=IDLE.
  - Opcode and Immed_in are combinational from Instr, so they are 0.
- States: IDLE, FETCH, HOLD.
  - IDLE: one cycle after reset release, then go to FETCH.
  - FETCH:
    - Imem_req=1 and Imem_addr=PC throughout.
    - On Imem_ack=1: Instr<=Imem_data, Instr_valid<=1, Imem_req<=0 (registered), go to HOLD.
    - Ack in the first FETCH cycle is legal; minimum latency is 1 cycle from req to latched word.
    - PC_LdEn, PC_sel and Immed_PC are ignored; PC stays stable while a request is outstanding.
  - HOLD:
    - Instr_valid=1; Instr is stable.
    - If PC_LdEn=1: PC<=next_pc, Instr_valid<=0, go to FETCH.
    - If PC_LdEn=0: stay (stall).
- next_pc:
  - PC_sel=0: PC+32'd4.
  - PC_sel=1: PC+32'd4+Immed_PC.
  - Modulo-2^32 wrap, no overflow flag; bits[1:0] forced to 00.
- Imem_ack outside FETCH is ignored: no latch, no state change.
- Reset mid-fetch: the request drops immediately (async). A late ack after reset release is ignored unless the block is back in FETCH; an ack arriving in IDLE is dropped.
- PC_LdEn and ack can never coincide in effect: PC_LdEn acts only in HOLD, ack only in FETCH.
- Throughput: at most one instruction per 2 cycles (FETCH, then HOLD).

Optional Feature:
IFU_TIMEOUT_EN
- Defined:
  - An 8+ bit counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: Fetch_err<=1 (sticky until reset), Imem_req<=0, go to IDLE and re-fetch the same PC.
- Undefined: no counter and no Fetch_err port; FETCH waits indefinitely.

Decomposition:
- Shared package (ifu_pkg):
  - state encoding localparams: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2
  - OPC_MSB=31, OPC_LSB=26, IMM_W=16, PC_INC=32'd4
- Sub-module pc_next_calc: combinational next_pc adder and alignment mask, reusable by a later branch-predict stage.
- FSM, registers and timeout counter stay in the top module.

Test Plan:
1. Reset release, memory returns 32'h2001_001D with ack one cycle after req -> Imem_addr=0, Instr_valid=1 in the next cycle, Opcode=6'b001000, Immed_in=32'h0000_001D.
2. In HOLD, PC_LdEn=1, PC_sel=0 -> PC=4, Instr_valid drops for at least one cycle, Imem_req=1 with Imem_addr=4.
3. PC=8, PC_sel=1, Immed_PC=32'hFFFF_FFF4 (-12), PC_LdEn=1 -> PC=0 (8+4-12).
4. Ack delayed 5 cycles while PC_LdEn=1 pulses -> PC unchanged, Imem_req held high, Instr latched only on the ack cycle.
5. Rst_n pulled low mid-FETCH, ack arrives in IDLE -> Imem_req=0 at once, Instr stays 0, PC=RESET_PC.
6. With IFU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> Fetch_err=1 after 4 FETCH cycles, refetch of the same PC, Fetch_err remains 1.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction field positions and the sequential PC increment.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } ifu_state_e;

  localparam int          OPC_MSB = 31;
  localparam int          OPC_LSB = 26;
  localparam int          IMM_W   = 16;
  localparam logic [31:0] PC_INC  = 32'd4;

  function automatic logic [5:0] get_opcode(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [31:0] get_raw_imm(input logic [31:0] instr);
    return {{(32-IMM_W){1'b0}}, instr[IMM_W-1:0]};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential or PC-relative branch target, word aligned.
import ifu_pkg::*;

module pc_next_calc (
  input  logic [31:0] pc_i,
  input  logic        sel_i,
  input  logic [31:0] immed_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] offset_s;
  logic [31:0] sum_s;

  always_comb begin
    offset_s = 32'd0;
    if (sel_i) begin
      offset_s = immed_i;
    end else begin
      offset_s = 32'd0;
    end
    sum_s     = pc_i + PC_INC + offset_s;
    next_pc_o = sum_s & ~32'd3;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, req/ack fetch FSM and instruction latch.
// Optional ack timeout with sticky Fetch_err when IFU_TIMEOUT_EN is defined.
import ifu_pkg::*;

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IFU_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        PC_LdEn,
  input  logic        PC_sel,
  input  logic [31:0] Immed_PC,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_data,
  output logic [31:0] Instr,
  output logic [5:0]  Opcode,
  output logic [31:0] Immed_in,
  output logic        Instr_valid,
  output logic [31:0] PC
`ifdef IFU_TIMEOUT_EN
  ,
  output logic        Fetch_err
`endif
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  pc_next_calc u_pc_next_calc (
    .pc_i      (pc_q),
    .sel_i     (PC_sel),
    .immed_i   (Immed_PC),
    .next_pc_o (pc_d)
  );

  // Fetch FSM; PC only moves in HOLD, the word is only latched in FETCH
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
`ifdef IFU_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        FETCH: begin
          if (Imem_ack) begin
            instr_q <= Imem_data;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end
`ifdef IFU_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
`endif
        end
        HOLD: begin
          if (PC_LdEn) begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FETCH;
`ifdef IFU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Imem_req    = req_q;
  assign Imem_addr   = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign Instr_valid = valid_q;
  assign Opcode      = get_opcode(instr_q);
  assign Immed_in    = get_raw_imm(instr_q);
`ifdef IFU_TIMEOUT_EN
  assign Fetch_err   = err_q;
`endif

endmodule
